// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: memory word, write mask and the memory port
// arbiter's FSM state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_A = 3'd1,
        BUSY_B = 3'd2,
        RESP_A = 3'd3,
        RESP_B = 3'd4
    } lc3b_arb_state;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises the instruction (A) and data (B) ports onto one physical memory
// port, one outstanding access at a time. Define ARB_ROUND_ROBIN_EN for
// round-robin conflict resolution; otherwise port B always wins.
//
// state  | meaning
// IDLE   | no access in flight; sample a_read / b_read|b_write
// BUSY_A | port A read on pmem, waiting for pmem_resp
// BUSY_B | port B read or write on pmem, waiting for pmem_resp
// RESP_A | a_resp pulse, a_rdata valid
// RESP_B | b_resp pulse, b_rdata valid (reads only)
module mem_port_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  lc3b_word      a_addr,
    input  logic          a_read,
    output lc3b_word      a_rdata,
    output logic          a_resp,
    input  lc3b_word      b_addr,
    input  logic          b_read,
    input  logic          b_write,
    input  lc3b_word      b_wdata,
    input  lc3b_mem_wmask b_byte_enable,
    output lc3b_word      b_rdata,
    output logic          b_resp,
    output lc3b_word      pmem_addr,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_wdata,
    output lc3b_mem_wmask pmem_byte_enable,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
);

    lc3b_arb_state state;
    logic          a_req;
    logic          b_req;
    logic          prefer_b;
    logic          pick_b;

    function automatic logic select_b(input logic req_a, input logic req_b,
                                      input logic b_first);
        return req_b && (!req_a || b_first);
    endfunction

    assign a_req = a_read;
    assign b_req = b_read | b_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;  // 0 = A, 1 = B
    assign prefer_b = ~last_grant;
`else
    assign prefer_b = 1'b1;
`endif

    assign pick_b = select_b(a_req, b_req, prefer_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            a_rdata          <= '0;
            a_resp           <= 1'b0;
            b_rdata          <= '0;
            b_resp           <= 1'b0;
            pmem_addr        <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        if (pick_b) begin
                            state            <= BUSY_B;
                            pmem_addr        <= b_addr;
                            pmem_wdata       <= b_wdata;
                            // simultaneous read+write is treated as a write
                            pmem_write       <= b_write;
                            pmem_read        <= ~b_write;
                            pmem_byte_enable <= b_write ? b_byte_enable : 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
                            last_grant       <= 1'b1;
`endif
                        end else begin
                            state            <= BUSY_A;
                            pmem_addr        <= a_addr;
                            pmem_write       <= 1'b0;
                            pmem_read        <= 1'b1;
                            pmem_byte_enable <= 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
                            last_grant       <= 1'b0;
`endif
                        end
                    end
                end
                BUSY_A: begin
                    if (pmem_resp) begin
                        a_rdata    <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        a_resp     <= 1'b1;
                        state      <= RESP_A;
                    end
                end
                BUSY_B: begin
                    if (pmem_resp) begin
                        if (!pmem_write) begin
                            b_rdata <= pmem_rdata;
                        end
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        b_resp     <= 1'b1;
                        state      <= RESP_B;
                    end
                end
                RESP_A, RESP_B: begin
                    a_resp <= 1'b0;
                    b_resp <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
